// File: rtl/lru_arbiter.sv
// Four-way least-recently-granted arbiter with a live LRU order export.
// Optional grant timeout/preemption is enabled with `define LRU_ARB_TIMEOUT_EN.
module lru_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic [7:0] lru_order,
  output logic       preempt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] gnt_id_q, gnt_id_d;
  logic       busy_q, busy_d;
  logic [7:0] lru_q, lru_d;

  logic       win_found_s;
  logic [1:0] win_id_s;
  logic [1:0] win_slot_s;
  logic [7:0] lru_upd_s;

  if (MAX_HOLD < 2) begin : g_bad_max_hold
    $error("lru_arbiter: MAX_HOLD must be at least 2");
  end

`ifdef LRU_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_q, hold_d;
  logic          preempt_q, preempt_d;
  logic          others_s;

  assign others_s = |(req & ~gnt_q);
`endif

  // Winner search: walk slots from most to least recent so the lowest hit survives.
  always_comb begin
    logic       hit;
    logic [1:0] id;
    win_found_s = 1'b0;
    win_id_s    = 2'd0;
    win_slot_s  = 2'd0;
    for (int s = 3; s >= 0; s--) begin
      id          = lru_q[2*s +: 2];
      hit         = req[id];
      win_found_s = win_found_s | hit;
      win_id_s    = hit ? id : win_id_s;
      win_slot_s  = hit ? 2'(s) : win_slot_s;
    end
  end

  // Order after a grant: winner to slot 3, later slots slide down by one.
  always_comb begin
    lru_upd_s = 8'h00;
    for (int s = 0; s < 3; s++) begin
      lru_upd_s[2*s +: 2] = (2'(s) < win_slot_s) ? lru_q[2*s +: 2] : lru_q[2*s+2 +: 2];
    end
    lru_upd_s[7:6] = win_id_s;
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    busy_d   = busy_q;
    lru_d    = lru_q;
`ifdef LRU_ARB_TIMEOUT_EN
    hold_d    = hold_q;
    preempt_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (win_found_s) begin
          state_d  = GRANT;
          gnt_d    = 4'b0001 << win_id_s;
          gnt_id_d = win_id_s;
          busy_d   = 1'b1;
          lru_d    = lru_upd_s;
`ifdef LRU_ARB_TIMEOUT_EN
          hold_d   = {HW{1'b0}};
`endif
        end else begin
          busy_d = 1'b0;
        end
      end
      GRANT: begin
        if (!req[gnt_id_q]) begin
          state_d  = RELEASE;
          gnt_d    = 4'b0000;
          gnt_id_d = 2'd0;
          busy_d   = 1'b1;
`ifdef LRU_ARB_TIMEOUT_EN
        end else if ((hold_q >= HW'(MAX_HOLD - 1)) && others_s) begin
          state_d   = RELEASE;
          gnt_d     = 4'b0000;
          gnt_id_d  = 2'd0;
          busy_d    = 1'b1;
          preempt_d = 1'b1;
        end else begin
          // Saturate so a late competitor still sees the expiry condition.
          hold_d = (hold_q >= HW'(MAX_HOLD - 1)) ? hold_q : hold_q + HW'(1);
        end
`else
        end else begin
          busy_d = 1'b1;
        end
`endif
      end
      RELEASE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d  = IDLE;
        gnt_d    = 4'b0000;
        gnt_id_d = 2'd0;
        busy_d   = 1'b0;
        lru_d    = 8'hE4;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= 4'b0000;
      gnt_id_q <= 2'd0;
      busy_q   <= 1'b0;
      lru_q    <= 8'hE4;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      busy_q   <= busy_d;
      lru_q    <= lru_d;
    end
  end

`ifdef LRU_ARB_TIMEOUT_EN
  // Hold counter and preempt pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q    <= {HW{1'b0}};
      preempt_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end

  assign preempt = preempt_q;
`else
  assign preempt = 1'b0;
`endif

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign busy      = busy_q;
  assign lru_order = lru_q;

endmodule
